// File: rtl/layer_sequencer.sv
// ============================================================================
// Module      : layer_sequencer
// Description : Sample-level controller that runs one layer instance through an
//               inference (or inference + STDP) window per accepted volley and
//               returns the winner. Optional perf counters: SEQ_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_sequencer #(
    parameter int NUM_SPIKES     = 8,
    parameter int NEURONS        = 4,
    parameter int TP_W           = 3,
    parameter int TESTING_PERIOD = 8,
    parameter int TIME_W         = 4,
    parameter int NW             = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_SPIKES*(TP_W+1)-1:0] in_spike_times,
    input  logic                           in_train,
    output logic [TIME_W:0]                time_val,
    output logic                           training,
    output logic [NUM_SPIKES*(TP_W+1)-1:0] spike_times,
    input  logic [TP_W:0]                  layer_spike_time,
    input  logic [NW:0]                    layer_winner,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NW:0]                    out_winner,
    output logic [TP_W:0]                  out_spike_time,
    output logic                           out_train
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0]                    cnt_samples,
    output logic [15:0]                    cnt_nospike
`endif
);

    localparam int TIME_PERIOD = TESTING_PERIOD + NEURONS;
    localparam logic [TIME_W:0] FLUSH_T    = (TIME_W+1)'(TIME_PERIOD - 1);
    localparam logic [TIME_W:0] LAST_TRAIN = (TIME_W+1)'(TIME_PERIOD - 1);
    localparam logic [TIME_W:0] LAST_INFER = (TIME_W+1)'(TESTING_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t          state;
    logic            train_q;
    logic [TIME_W:0] last_t;

    assign last_t = train_q ? LAST_TRAIN : LAST_INFER;

    // The spike_times register doubles as the volley latch during RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            train_q        <= 1'b0;
            in_ready       <= 1'b1;
            out_valid      <= 1'b0;
            training       <= 1'b0;
            time_val       <= FLUSH_T;
            spike_times    <= '1;
            out_winner     <= '1;
            out_spike_time <= '1;
            out_train      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        spike_times <= in_spike_times;
                        train_q     <= in_train;
                        training    <= in_train;
                        time_val    <= '0;
                        in_ready    <= 1'b0;
                        state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (time_val == last_t) begin
                        out_winner     <= layer_winner;
                        out_spike_time <= layer_spike_time;
                        out_train      <= train_q;
                        // Return to the flush value with training already low.
                        time_val       <= FLUSH_T;
                        training       <= 1'b0;
                        spike_times    <= '1;
                        out_valid      <= 1'b1;
                        state          <= S_REPORT;
                    end else begin
                        time_val <= time_val + 1'b1;
                    end
                end
                S_REPORT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic report_hs;
    assign report_hs = (state == S_REPORT) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_samples <= '0;
            cnt_nospike <= '0;
        end else if (report_hs) begin
            if (cnt_samples != 16'hFFFF) cnt_samples <= cnt_samples + 16'd1;
            if (out_spike_time[TP_W] && (cnt_nospike != 16'hFFFF))
                cnt_nospike <= cnt_nospike + 16'd1;
        end
    end
`else
    // Counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Sample-level controller that sequences one `layer` instance.
- Accepts one input volley (spike times plus a train/infer flag) per sample over a valid/ready handshake.
- Drives the layer's `time_val`, `training` and `spike_times` for one full sample window.
- Captures the winning neuron and output spike time and returns them over a second valid/ready handshake.
- Sits between the sample source/testbench and `layer`; the layer is unmodified.

Parameters:
- NUM_SPIKES, 8: input lines per volley.
- NEURONS, 4: neurons per layer; length of the STDP window.
- TP_W, 3: log2 of the testing period; spike time field is TP_W+1 bits, MSB=1 means no spike.
- TESTING_PERIOD, 8: cycles in the inference window; equals 2**TP_W.
- TIME_W, 4: `time_val` width minus 1; bus is TIME_W+1 bits.
- NW, 2: winner field width minus 1; bus is NW+1 bits.
- Derived: TIME_PERIOD = TESTING_PERIOD + NEURONS.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous assert, active-high
- in_valid  in  1  volley offered
- in_ready  out  1  sequencer can accept a volley
- in_spike_times  in  NUM_SPIKES*(TP_W+1)  per-line spike time, MSB = disable
- in_train  in  1  1 = run STDP window, 0 = inference only
- time_val  out  TIME_W+1  to layer
- training  out  1  to layer
- spike_times  out  NUM_SPIKES*(TP_W+1)  to layer
- layer_spike_time  in  TP_W+1  from layer `output_spike_time`
- layer_winner  in  NW+1  from layer `winning_neuron`
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_winner  out  NW+1  captured winner; all-ones = no spike
- out_spike_time  out  TP_W+1  captured spike time; MSB=1 = no spike
- out_train  out  1  echo of in_train for this sample

Behaviour:
- Reset values:
  - State IDLE.
  - in_ready=1, out_valid=0, training=0.
  - time_val = TIME_PERIOD-1. This is the layer's flush value: its outputs stay cleared and its weights are untouched.
  - spike_times all-ones, i.e. every line disabled.
  - out_winner all-ones, out_spike_time all-ones, out_train=0.
- States: IDLE, RUN, REPORT.
- IDLE:
  - in_ready=1; time_val held at TIME_PERIOD-1; training=0; spike_times all-ones.
  - On in_valid&in_ready:
    - Latch in_spike_times and in_train.
    - Next cycle: time_val=0 and training=latched in_train → RUN.
- RUN:
  - in_ready=0; spike_times = latched volley, held stable.
  - time_val increments by 1 per cycle. LAST = TIME_PERIOD-1 if train, else TESTING_PERIOD-1.
  - Cycle with time_val==LAST:
    - Register layer_winner, layer_spike_time and train into the out_* fields.
    - Next cycle: time_val=TIME_PERIOD-1, training=0, spike_times all-ones → REPORT.
- REPORT:
  - out_valid=1; out_* stable while out_valid is high and out_ready is low.
  - On out_ready: out_valid=0 next cycle → IDLE; in_ready=1 in that IDLE cycle.
  - No accept while in REPORT.
- Latency, with accept at cycle A:
  - Inference: time_val=0 at A+1, out_valid at A+TESTING_PERIOD+1.
  - Training: out_valid at A+TIME_PERIOD+1.
  - Back-to-back throughput with out_ready tied high: one sample per LAST+3 cycles.
- time_val never wraps: the counter stops at LAST, and no value above TIME_PERIOD-1 is ever driven.
- training is 1 only in RUN; it must never be 1 with time_val=TIME_PERIOD-1 outside RUN, or weights would be corrupted.
- in_valid with in_ready low: ignored, no latch.
- Reset mid-RUN or mid-REPORT: immediate return to reset values. A partially written STDP row is not rolled back.
- No spike in the window: layer reports all-ones; passed through unchanged.

Optional Feature:
- SEQ_PERF_CNT_EN defined:
  - Adds outputs cnt_samples[15:0] and cnt_nospike[15:0], both cleared on reset.
  - cnt_samples increments on each REPORT handshake.
  - cnt_nospike increments on each REPORT handshake where out_spike_time MSB=1.
  - Both saturate at 16'hFFFF.
- SEQ_PERF_CNT_EN undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle 5 cycles → in_ready=1, out_valid=0, time_val=11, training=0, spike_times all-ones.
- Infer sample: line0=0, others 4'b1xxx, in_train=0, accepted at cycle 10, out_ready=1:
  - time_val=0..7 on cycles 11..18; training=0 throughout.
  - out_valid at 19 with out_train=0.
  - out_winner/out_spike_time equal layer values sampled at cycle 18.
- Train sample accepted at cycle 10:
  - training=1 and time_val=0..11 on cycles 11..22.
  - training=0 at 23; out_valid at 23.
- Backpressure: hold out_ready=0 for 6 cycles in REPORT → out_* stable, in_ready=0; in_valid pulses are ignored. Then out_ready=1 → IDLE and in_ready=1 the next cycle.
- Reset asserted at time_val=5 of a train run → outputs at reset values immediately; next accepted sample restarts at time_val=0.
- SEQ_PERF_CNT_EN: 3 samples, one with all lines disabled → cnt_samples=3, cnt_nospike=1.
